mem_bus_ctrl: RTL



---
 rtl/mem_bus_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: RISC240 memory bus controller with wait states, word RAM and sticky bus error.
// Define MEM_BUS_MMIO_EN to add the LED/switch/cycle-counter window at FFF0..FFFE.
module mem_bus_ctrl #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic [15:0] memAddr,
  inout  wire  [15:0] dataBus,
  input  logic        re_L,
  input  logic        we_L,
  output logic        memRdy_L,
  output logic        busErr,
  input  logic        clrErr_L,
  input  logic [15:0] switches,
  output logic [15:0] leds
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [14:0] idx_q, idx_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d, rd_val;
  logic bus_err_q, bus_err_d;
  logic start, proto_err, held, go_ack, in_ram, bad, err_set, ram_we;
  logic [15:0] mem [MEM_WORDS];
`ifdef MEM_BUS_MMIO_EN
  logic [15:0] leds_q, leds_d, cyc_q;
  logic mmio;
  logic unused_in;
  assign unused_in = memAddr[0];
`else
  logic unused_in;
  assign unused_in = ^{memAddr[0], switches};
`endif
  always_comb begin
    start = re_L ^ we_L;
    proto_err = !re_L && !we_L;
    held = wr_q ? !we_L : !re_L;
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        wr_d = !we_L;
        idx_d = memAddr[15:1];
        wdata_d = dataBus;
        cnt_d = CNT_INIT;
        state_d = WAIT_CYCLES == 0 ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        state_d = !held ? S_IDLE : cnt_q == 4'd0 ? S_ACK : S_WAIT;
        cnt_d = held && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
      end
      default: state_d = S_IDLE;
    endcase
    // On the ACK-entry edge the *_d values describe the access, whether latched or live
    go_ack = state_d == S_ACK && state_q != S_ACK;
    in_ram = {17'd0, idx_d} < 32'(MEM_WORDS);
    rd_val = in_ram ? mem[idx_d[AW-1:0]] : 16'h0000;
    bad = !in_ram;
`ifdef MEM_BUS_MMIO_EN
    mmio = idx_d[14:3] == 12'hFFF;
    in_ram = in_ram && !mmio;
    rd_val = !mmio ? rd_val : idx_d[2:0] == 3'd0 ? leds_q : idx_d[2:0] == 3'd1 ? switches :
             idx_d[2:0] == 3'd2 ? cyc_q : 16'h0000;
    bad = mmio ? wr_d && idx_d[2:0] > 3'd2 : bad;
    leds_d = go_ack && wr_d && mmio && idx_d[2:0] == 3'd0 ? wdata_d : leds_q;
`endif
    ram_we = go_ack && wr_d && in_ram && reset_L;
    rdata_d = go_ack ? rd_val : rdata_q;
    err_set = state_q == S_IDLE && proto_err || go_ack && bad;
    bus_err_d = err_set ? 1'b1 : !clrErr_L ? 1'b0 : bus_err_q;
  end
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  always_ff @(posedge clock)
    if (ram_we) mem[idx_d[AW-1:0]] <= wdata_d;
`ifdef MEM_BUS_MMIO_EN
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      leds_q <= '0;
      cyc_q <= '0;
    end else begin
      leds_q <= leds_d;
      cyc_q <= cyc_q + 16'd1;
    end
  assign leds = leds_q;
`else
  assign leds = 16'h0000;
`endif
  assign memRdy_L = state_q != S_ACK;
  assign busErr = bus_err_q;
  assign dataBus = state_q == S_ACK && !wr_q && !re_L ? rdata_q : 16'hzzzz;
endmodule
